// File: rtl/writeback_cycle.sv
// Writeback stage: MEM/WB register, load/ALU source mux, integer register file and retire counter.
// Optional macro WB_FORWARD_EN: register-file reads forward the in-flight WB value (write-through).
module writeback_cycle #(
  parameter int XLEN       = 64,
  parameter int REG_COUNT  = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic                  mem_rd_write_enable,
  input  logic                  dm_read_enable,
  input  logic [XLEN-1:0]       dm_read_data,
  input  logic [XLEN-1:0]       dm_data_bypass,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_rd_addr,
  output logic                  wb_rd_write_enable,
  output logic [XLEN-1:0]       wb_data,
  output logic [63:0]           retired_count
);

  logic                  r_wb_valid;
  logic [REG_ADDR_W-1:0] r_wb_rd_addr;
  logic                  r_wb_we;
  logic [XLEN-1:0]       r_wb_data;
  logic [63:0]           r_retired;
  logic [XLEN-1:0]       r_regs [REG_COUNT];

  logic [XLEN-1:0]       w_mux_data;
  logic                  w_rf_write;

  assign w_mux_data = dm_read_enable ? dm_read_data : dm_data_bypass;
  assign w_rf_write = r_wb_valid && r_wb_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_valid   <= 1'b0;
      r_wb_rd_addr <= '0;
      r_wb_we      <= 1'b0;
      r_wb_data    <= '0;
    end else if (flush) begin
      r_wb_valid   <= 1'b0;
      r_wb_rd_addr <= '0;
      r_wb_we      <= 1'b0;
      r_wb_data    <= '0;
    end else if (!stall) begin
      r_wb_valid   <= mem_valid;
      r_wb_rd_addr <= mem_rd_addr;
      r_wb_we      <= mem_rd_write_enable && (mem_rd_addr != '0);
      r_wb_data    <= w_mux_data;
    end
  end

  // An instruction retires when it leaves WB; flush alone does not cancel that.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_retired <= '0;
    end else if (r_wb_valid && !stall) begin
      r_retired <= r_retired + 64'd1;
    end
  end

  // x0 is never written because r_wb_we is already cleared for index 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_rf_write) begin
      r_regs[r_wb_rd_addr] <= r_wb_data;
    end
  end

  function automatic logic [XLEN-1:0] f_read(input logic [REG_ADDR_W-1:0] a);
    logic [XLEN-1:0] v;
    v = r_regs[a];
`ifdef WB_FORWARD_EN
    if (w_rf_write && (r_wb_rd_addr == a)) begin
      v = r_wb_data;
    end
`endif
    if (a == '0) begin
      v = '0;
    end
    return v;
  endfunction

  assign rs1_data           = f_read(rs1_addr);
  assign rs2_data           = f_read(rs2_addr);
  assign wb_valid           = r_wb_valid;
  assign wb_rd_addr         = r_wb_rd_addr;
  assign wb_rd_write_enable = r_wb_we;
  assign wb_data            = r_wb_data;
  assign retired_count      = r_retired;

endmodule

// File: tb/tb_writeback_cycle.sv
// Scoreboard bench for writeback_cycle: driver pushes expected outputs, negedge monitor compares.
// Reference model tracks the architectural register file, WB slot and retire count.
module tb_writeback_cycle;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic [4:0]  mem_rd_addr;
  logic        mem_rd_write_enable;
  logic        dm_read_enable;
  logic [63:0] dm_read_data;
  logic [63:0] dm_data_bypass;
  logic        stall;
  logic        flush;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic        wb_rd_write_enable;
  logic [63:0] wb_data;
  logic [63:0] retired_count;

  always #5 clk = ~clk;

  writeback_cycle dut (
    .clk                (clk),
    .reset              (reset),
    .mem_valid          (mem_valid),
    .mem_rd_addr        (mem_rd_addr),
    .mem_rd_write_enable(mem_rd_write_enable),
    .dm_read_enable     (dm_read_enable),
    .dm_read_data       (dm_read_data),
    .dm_data_bypass     (dm_data_bypass),
    .stall              (stall),
    .flush              (flush),
    .rs1_addr           (rs1_addr),
    .rs2_addr           (rs2_addr),
    .rs1_data           (rs1_data),
    .rs2_data           (rs2_data),
    .wb_valid           (wb_valid),
    .wb_rd_addr         (wb_rd_addr),
    .wb_rd_write_enable (wb_rd_write_enable),
    .wb_data            (wb_data),
    .retired_count      (retired_count)
  );

  typedef struct {
    string       name;
    logic        wv;
    logic [4:0]  wrd;
    logic        wwe;
    logic [63:0] wd;
    logic [63:0] rc;
    logic [63:0] r1;
    logic [63:0] r2;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: architectural state as the spec describes it.
  logic        m_valid;
  logic [4:0]  m_rd;
  logic        m_we;
  logic [63:0] m_data;
  logic [63:0] m_ret;
  logic [63:0] m_regs [32];

  task automatic model_reset();
    m_valid = 1'b0; m_rd = '0; m_we = 1'b0; m_data = '0; m_ret = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
  endtask

  function automatic logic [63:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 64'd0;
`ifdef WB_FORWARD_EN
    if (m_valid && m_we && m_rd == a) return m_data;
`endif
    return m_regs[a];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic cycle(input string name, input logic v, input logic [4:0] rd, input logic we,
                       input logic ld, input logic [63:0] rdata, input logic [63:0] byp,
                       input logic st, input logic fl, input logic [4:0] a1, input logic [4:0] a2);
    mem_valid = v; mem_rd_addr = rd; mem_rd_write_enable = we; dm_read_enable = ld;
    dm_read_data = rdata; dm_data_bypass = byp; stall = st; flush = fl;
    rs1_addr = a1; rs2_addr = a2;
    sb.push_back('{name, m_valid, m_rd, m_we, m_data, m_ret, m_read(a1), m_read(a2)});
    @(posedge clk);
    if (m_valid && m_we) m_regs[m_rd] = m_data;
    if (m_valid && !st) m_ret = m_ret + 64'd1;
    if (fl) begin
      m_valid = 1'b0; m_rd = '0; m_we = 1'b0; m_data = '0;
    end else if (!st) begin
      m_valid = v; m_rd = rd; m_we = we && (rd != 5'd0); m_data = ld ? rdata : byp;
    end
    #1;
    $display("[TB] %s v=%0d rd=%0d we=%0d ld=%0d st=%0d fl=%0d", name, v, rd, we, ld, st, fl);
  endtask

  task automatic idle(input string name, input logic [4:0] a1, input logic [4:0] a2);
    cycle(name, 1'b0, 5'd0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, a1, a2);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.name, ".wb_valid"}, {63'd0, wb_valid}, {63'd0, e.wv});
      check({e.name, ".wb_rd_addr"}, {59'd0, wb_rd_addr}, {59'd0, e.wrd});
      check({e.name, ".wb_we"}, {63'd0, wb_rd_write_enable}, {63'd0, e.wwe});
      check({e.name, ".wb_data"}, wb_data, e.wd);
      check({e.name, ".retired"}, retired_count, e.rc);
      check({e.name, ".rs1_data"}, rs1_data, e.r1);
      check({e.name, ".rs2_data"}, rs2_data, e.r2);
    end
  end

  initial begin
    reset = 1'b1;
    mem_valid = 0; mem_rd_addr = 0; mem_rd_write_enable = 0; dm_read_enable = 0;
    dm_read_data = 0; dm_data_bypass = 0; stall = 0; flush = 0; rs1_addr = 0; rs2_addr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 32; i++) idle("reset_read", 5'(i), 5'(31 - i));

    cycle("alu_rd5", 1, 5'd5, 1, 0, 64'hAAAA, 64'h1234, 0, 0, 5'd5, 5'd0);
    idle("alu_rd5_wb", 5'd5, 5'd0);
    idle("alu_rd5_read", 5'd5, 5'd5);

    cycle("load_rd7", 1, 5'd7, 1, 1, 64'hFFFF_FFFF_FFFF_FF80, 64'd0, 0, 0, 5'd7, 5'd0);
    idle("load_rd7_same", 5'd7, 5'd7);
    idle("load_rd7_after", 5'd7, 5'd5);

    cycle("rd0_write", 1, 5'd0, 1, 0, 64'd0, 64'hDEAD, 0, 0, 5'd0, 5'd0);
    idle("rd0_wb", 5'd0, 5'd0);
    idle("rd0_after", 5'd0, 5'd7);

    cycle("stall_issue", 1, 5'd9, 1, 0, 64'd0, 64'h9999, 0, 0, 5'd9, 5'd0);
    for (int i = 0; i < 3; i++)
      cycle("stall_hold", 1, 5'd10, 1, 0, 64'd0, 64'h1010, 1, 0, 5'd9, 5'd10);
    idle("stall_drop", 5'd9, 5'd10);
    cycle("fs_issue", 1, 5'd11, 1, 0, 64'd0, 64'h1111, 0, 0, 5'd11, 5'd0);
    cycle("flush_stall", 1, 5'd12, 1, 0, 64'd0, 64'h1212, 1, 1, 5'd11, 5'd12);
    idle("flush_after", 5'd11, 5'd12);

    cycle("x3_write", 1, 5'd3, 1, 0, 64'd0, 64'h55, 0, 0, 5'd3, 5'd0);
    idle("x3_wb", 5'd3, 5'd0);
    idle("x3_read", 5'd3, 5'd3);
    rs1_addr = 5'd3; rs2_addr = 5'd5;
    #2 reset = 1'b1;
    #1;
    check("async_rst.x3", rs1_data, 64'd0);
    check("async_rst.x5", rs2_data, 64'd0);
    check("async_rst.wb_valid", {63'd0, wb_valid}, 64'd0);
    check("async_rst.wb_data", wb_data, 64'd0);
    check("async_rst.retired", retired_count, 64'd0);
    model_reset();
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    idle("post_reset", 5'd3, 5'd7);

    for (int i = 0; i < 1500; i++) begin
      cycle("rand",
            1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) == 0),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    repeat (3) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
